// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: shared prescaled time base, double-buffered config.
// Optional complementary outputs with dead time when PWM_DEADTIME_EN is defined.
module pwm_gen_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pwm_en,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic [CNT_W-1:0]        period,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [CNT_W*NUM_CH-1:0] compare1,
    input  logic [CNT_W*NUM_CH-1:0] compare2,
    input  logic                    cfg_load,
`ifdef PWM_DEADTIME_EN
    input  logic [7:0]              dead_time,
    output logic [NUM_CH-1:0]       pwm_out_n,
`endif
    output logic                    cfg_pending,
    output logic [CNT_W-1:0]        count_val,
    output logic                    period_tick,
    output logic [NUM_CH-1:0]       pwm_out
);

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ptick_q;
    logic                    pend_q;
    logic [CNT_W-1:0]        sh_per_q, act_per_q;
    logic [2*NUM_CH-1:0]     sh_mode_q, act_mode_q;
    logic [CNT_W*NUM_CH-1:0] sh_c1_q, sh_c2_q, act_c1_q, act_c2_q;
    logic [NUM_CH-1:0]       out_q;
    logic [NUM_CH-1:0]       ge1, lt2, raw;
    logic                    tick, wrap;

    // Compare with >= so a prescale/period shrink can never stall the count.
    assign tick = presc_q >= prescale;
    assign wrap = tick && (cnt_q >= act_per_q);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = cnt_q;
        if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        ge1 = '0;
        lt2 = '0;
        raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ge1[i] = cnt_q >= act_c1_q[CNT_W*i +: CNT_W];
            lt2[i] = cnt_q < act_c2_q[CNT_W*i +: CNT_W];
            case (act_mode_q[2*i +: 2])
                2'b00:   raw[i] = !ge1[i];
                2'b01:   raw[i] = ge1[i];
                2'b10:   raw[i] = ge1[i] & lt2[i];
                default: raw[i] = !(ge1[i] & lt2[i]);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            ptick_q    <= 1'b0;
            pend_q     <= 1'b0;
            sh_per_q   <= '0;
            sh_mode_q  <= '0;
            sh_c1_q    <= '0;
            sh_c2_q    <= '0;
            act_per_q  <= '0;
            act_mode_q <= '0;
            act_c1_q   <= '0;
            act_c2_q   <= '0;
        end else begin
            if (cfg_load) begin
                sh_per_q  <= period;
                sh_mode_q <= mode;
                sh_c1_q   <= compare1;
                sh_c2_q   <= compare2;
            end
            if (!pwm_en) begin
                presc_q    <= '0;
                cnt_q      <= '0;
                ptick_q    <= 1'b0;
                pend_q     <= 1'b0;
                act_per_q  <= period;
                act_mode_q <= mode;
                act_c1_q   <= compare1;
                act_c2_q   <= compare2;
            end else begin
                presc_q <= presc_d;
                cnt_q   <= cnt_d;
                ptick_q <= wrap;
                if (wrap && pend_q) begin
                    act_per_q  <= sh_per_q;
                    act_mode_q <= sh_mode_q;
                    act_c1_q   <= sh_c1_q;
                    act_c2_q   <= sh_c2_q;
                end
                if (cfg_load) begin
                    pend_q <= 1'b1;
                end else if (wrap) begin
                    pend_q <= 1'b0;
                end
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [NUM_CH-1:0] lvl_q, outn_q, edg, ok;
    logic [7:0]        dt_q [NUM_CH];

    // New side may assert once the gap counter has run down to its last clock.
    always_comb begin
        edg = '0;
        ok  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            edg[i] = raw[i] ^ lvl_q[i];
            ok[i]  = edg[i] ? (dead_time == 8'd0) : (dt_q[i] <= 8'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q  <= '0;
            out_q  <= '0;
            outn_q <= '0;
            for (int i = 0; i < NUM_CH; i++) dt_q[i] <= '0;
        end else if (!pwm_en) begin
            lvl_q  <= '0;
            out_q  <= '0;
            outn_q <= '0;
            for (int i = 0; i < NUM_CH; i++) dt_q[i] <= '0;
        end else begin
            lvl_q  <= raw;
            out_q  <= ch_en & raw & ok;
            outn_q <= ch_en & ~raw & ok;
            for (int i = 0; i < NUM_CH; i++) begin
                if (edg[i]) begin
                    dt_q[i] <= dead_time;
                end else if (dt_q[i] != 8'd0) begin
                    dt_q[i] <= dt_q[i] - 8'd1;
                end
            end
        end
    end

    assign pwm_out_n = outn_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= pwm_en ? (ch_en & raw) : '0;
        end
    end
`endif

    assign cfg_pending = pend_q;
    assign count_val   = cnt_q;
    assign period_tick = ptick_q;
    assign pwm_out     = out_q;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Bench for pwm_gen_multi: time-based reference model, vector table,
// hand-written corner sequences and a randomized run.
module tb_pwm_gen_multi;

    localparam int NC = 4;
    localparam int CW = 16;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_en = 1'b0;
    logic cfg_load = 1'b0;
    logic [NC-1:0] ch_en = '0;
    logic [PW-1:0] prescale = '0;
    logic [CW-1:0] period = '0;
    logic [2*NC-1:0] mode = '0;
    logic [CW*NC-1:0] compare1 = '0;
    logic [CW*NC-1:0] compare2 = '0;
    logic cfg_pending;
    logic [CW-1:0] count_val;
    logic period_tick;
    logic [NC-1:0] pwm_out;

    pwm_gen_multi #(.NUM_CH(NC), .CNT_W(CW), .PRESC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_en(pwm_en), .ch_en(ch_en),
        .prescale(prescale), .period(period), .mode(mode),
        .compare1(compare1), .compare2(compare2), .cfg_load(cfg_load),
        .cfg_pending(cfg_pending), .count_val(count_val),
        .period_tick(period_tick), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: clocks elapsed since the start of the current period.
    longint m_t;
    bit m_pend, m_ptick;
    bit [NC-1:0] m_out;
    int a_per, s_per;
    int a_mode[NC], a_c1[NC], a_c2[NC];
    int s_mode[NC], s_c1[NC], s_c2[NC];

    typedef struct {
        int md;
        int c1;
        int c2;
        int per;
        int exp_hi;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ref_raw(int m, int c1, int c2, int cnt);
        bit inwin;
        inwin = (cnt >= c1) && (cnt < c2);
        case (m)
            0: return cnt < c1;
            1: return cnt >= c1;
            2: return inwin;
            default: return !inwin;
        endcase
    endfunction

    function automatic int in_mode(int i);
        return int'(mode[2*i +: 2]);
    endfunction
    function automatic int in_c1(int i);
        return int'(compare1[CW*i +: CW]);
    endfunction
    function automatic int in_c2(int i);
        return int'(compare2[CW*i +: CW]);
    endfunction

    task automatic model_reset();
        m_t = 0; m_pend = 0; m_ptick = 0; m_out = '0;
        a_per = 0; s_per = 0;
        for (int i = 0; i < NC; i++) begin
            a_mode[i] = 0; a_c1[i] = 0; a_c2[i] = 0;
            s_mode[i] = 0; s_c1[i] = 0; s_c2[i] = 0;
        end
    endtask

    task automatic model_step();
        longint len, p1;
        int cnt;
        bit wrap;
        p1 = longint'(prescale) + 1;
        if (!pwm_en) begin
            m_t = 0; m_ptick = 0; m_out = '0; m_pend = 0;
            a_per = int'(period);
            for (int i = 0; i < NC; i++) begin
                a_mode[i] = in_mode(i); a_c1[i] = in_c1(i); a_c2[i] = in_c2(i);
            end
            if (cfg_load) begin
                s_per = int'(period);
                for (int i = 0; i < NC; i++) begin
                    s_mode[i] = in_mode(i); s_c1[i] = in_c1(i); s_c2[i] = in_c2(i);
                end
            end
        end else begin
            cnt = int'(m_t / p1);
            for (int i = 0; i < NC; i++)
                m_out[i] = ch_en[i] && ref_raw(a_mode[i], a_c1[i], a_c2[i], cnt);
            len = (longint'(a_per) + 1) * p1;
            wrap = (m_t == len - 1);
            m_ptick = wrap;
            m_t = wrap ? 0 : m_t + 1;
            if (wrap && m_pend) begin
                a_per = s_per; m_pend = 0;
                for (int i = 0; i < NC; i++) begin
                    a_mode[i] = s_mode[i]; a_c1[i] = s_c1[i]; a_c2[i] = s_c2[i];
                end
            end
            if (cfg_load) begin
                s_per = int'(period); m_pend = 1;
                for (int i = 0; i < NC; i++) begin
                    s_mode[i] = in_mode(i); s_c1[i] = in_c1(i); s_c2[i] = in_c2(i);
                end
            end
        end
    endtask

    task automatic check_all();
        chk("count_val", longint'(count_val), m_t / (longint'(prescale) + 1));
        chk("period_tick", longint'(period_tick), longint'(m_ptick));
        chk("cfg_pending", longint'(cfg_pending), longint'(m_pend));
        chk("pwm_out", longint'(pwm_out), longint'(m_out));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_ch(input int i, input int m, input int c1, input int c2);
        mode[2*i +: 2] = 2'(m);
        compare1[CW*i +: CW] = CW'(c1);
        compare2[CW*i +: CW] = CW'(c2);
    endtask

    task automatic set_all(input int m, input int c1, input int c2);
        for (int i = 0; i < NC; i++) set_ch(i, m, c1, c2);
    endtask

    task automatic wait_count(input int v);
        int n;
        n = 0;
        while (int'(count_val) != v && n < 200) begin
            cyc();
            n++;
        end
        chk($sformatf("reach_count_%0d", v), longint'(count_val), longint'(v));
    endtask

    task automatic tick_gap(output int gap);
        int n;
        n = 0;
        while (!period_tick && n < 200) begin
            cyc();
            n++;
        end
        n = 0;
        do begin
            cyc();
            n++;
        end while (!period_tick && n < 200);
        gap = n;
    endtask

    initial begin
        int gap, hi;
        vt[0] = '{md: 0, c1: 4,  c2: 10, per: 15, exp_hi: 4};
        vt[1] = '{md: 1, c1: 4,  c2: 10, per: 15, exp_hi: 12};
        vt[2] = '{md: 2, c1: 4,  c2: 10, per: 15, exp_hi: 6};
        vt[3] = '{md: 3, c1: 4,  c2: 10, per: 15, exp_hi: 10};
        vt[4] = '{md: 2, c1: 4,  c2: 2,  per: 15, exp_hi: 0};
        vt[5] = '{md: 3, c1: 4,  c2: 2,  per: 15, exp_hi: 16};
        vt[6] = '{md: 0, c1: 0,  c2: 0,  per: 15, exp_hi: 0};
        vt[7] = '{md: 0, c1: 20, c2: 0,  per: 15, exp_hi: 16};
        vt[8] = '{md: 1, c1: 0,  c2: 0,  per: 7,  exp_hi: 8};
        vt[9] = '{md: 0, c1: 3,  c2: 0,  per: 9,  exp_hi: 3};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count_val", longint'(count_val), 0);
        chk("rst_pwm_out", longint'(pwm_out), 0);
        chk("rst_period_tick", longint'(period_tick), 0);
        chk("rst_cfg_pending", longint'(cfg_pending), 0);
        rst_n = 1'b1;

        // Basic: period 9, left mode c1=3 on channel 0
        prescale = 0; period = 9; set_all(0, 3, 0); ch_en = 4'b0001;
        cyc();
        pwm_en = 1'b1;
        tick_gap(gap);
        chk("basic_tick_gap", gap, 10);

        // Prescaler
        pwm_en = 1'b0; prescale = 2; period = 4;
        cyc();
        pwm_en = 1'b1;
        tick_gap(gap);
        chk("presc_tick_gap", gap, 15);

        // Mode table
        prescale = 0; ch_en = '1;
        for (int k = 0; k < 10; k++) begin
            pwm_en = 1'b0;
            period = CW'(vt[k].per);
            set_all(vt[k].md, vt[k].c1, vt[k].c2);
            cyc(); cyc();
            pwm_en = 1'b1;
            hi = 0;
            for (int j = 0; j <= vt[k].per; j++) begin
                cyc();
                hi += int'(pwm_out[0]);
            end
            chk($sformatf("mode_vec_%0d_high", k), hi, vt[k].exp_hi);
        end

        // Mid-period shadow load
        pwm_en = 1'b0; period = 9; set_all(0, 3, 0);
        cyc();
        pwm_en = 1'b1;
        wait_count(4);
        period = 7; set_ch(0, 0, 2, 0); cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        chk("load_pending", longint'(cfg_pending), 1);
        tick_gap(gap);
        chk("load_new_gap", gap, 8);

        // Load on the wrap cycle applies one period later
        wait_count(7);
        period = 5; cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        chk("wrapload_pending", longint'(cfg_pending), 1);
        chk("wrapload_tick", longint'(period_tick), 1);
        tick_gap(gap);
        chk("wrapload_old_gap", gap, 8);
        tick_gap(gap);
        chk("wrapload_new_gap", gap, 6);

        // Disable mid-operation
        pwm_en = 1'b0; period = 9; set_all(1, 1, 0);
        cyc();
        pwm_en = 1'b1;
        wait_count(5);
        chk("pre_dis_pwm0", longint'(pwm_out[0]), 1);
        pwm_en = 1'b0;
        cyc();
        chk("dis_count", longint'(count_val), 0);
        chk("dis_pwm", longint'(pwm_out), 0);

        // Async reset with a pending load
        pwm_en = 1'b1;
        repeat (3) cyc();
        period = 3; cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        chk("prereset_pending", longint'(cfg_pending), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_pending", longint'(cfg_pending), 0);
        chk("areset_count", longint'(count_val), 0);
        chk("areset_pwm", longint'(pwm_out), 0);
        model_reset();
        #2 rst_n = 1'b1;
        repeat (4) cyc();
        chk("postreset_count", longint'(count_val), 0);
        chk("postreset_pending", longint'(cfg_pending), 0);

        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            if (pwm_en) begin
                if ($urandom_range(0, 59) == 0) pwm_en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                pwm_en = 1'b1;
            end
            if (!pwm_en) prescale = PW'($urandom_range(0, 3));
            period = CW'($urandom_range(0, 12));
            for (int i = 0; i < NC; i++)
                set_ch(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 14)),
                       int'($urandom_range(0, 14)));
            cfg_load = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) ch_en = NC'($urandom);
            cyc();
        end
        cfg_load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
